// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result producers and the register-file write port.
// The slave modport is the arbiter; the master modport is the environment side.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 2
);
    logic                      a_valid;
    logic [4:0]                a_rd;
    logic [31:0]               a_data;
    logic                      a_stall;

    logic                      b_valid;
    logic                      b_ready;
    logic [4:0]                b_rd;
    logic [31:0]               b_data;

    logic                      rf_we;
    logic [4:0]                rf_waddr;
    logic [31:0]               rf_wdata;

    logic [31:0]               pending;
    logic [$clog2(DEPTH):0]    fifo_count;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_stall, b_ready, rf_we, rf_waddr, rf_wdata, pending, fifo_count
    );

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_stall, b_ready, rf_we, rf_waddr, rf_wdata, pending, fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU results (A) have priority, load results (B)
// are buffered in a small FIFO whose head forces its way in after STARVE_LIMIT
// consecutive losses. Publishes a bitmap of registers with buffered writes.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,   // power of two, >= 2
    parameter int STARVE_LIMIT = 3    // >= 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_rf_we;
    logic [4:0]    r_rf_waddr;
    logic [31:0]   r_rf_wdata;

    logic          w_a_req;
    logic          w_head;
    logic          w_force;
    logic          w_issue_a;
    logic          w_pop;
    logic          w_b_ready;
    logic          w_push;
    logic [AW-1:0] w_slot_off;
    logic [31:0]   w_pending;

    // Issue selection: A wins unless the FIFO head has already lost STARVE_LIMIT times.
    always_comb begin
        w_a_req   = bus.a_valid && (bus.a_rd != 5'd0);
        w_head    = (r_count != '0);
        w_force   = w_head && (r_starve == SW'(STARVE_LIMIT));
        w_issue_a = w_a_req && !w_force;
        w_pop     = w_head && !w_issue_a;
        w_b_ready = (r_count != CW'(DEPTH));
        w_push    = bus.b_valid && w_b_ready && (bus.b_rd != 5'd0);
    end

    // Pending bitmap: one bit per destination of every occupied FIFO slot.
    always_comb begin
        w_pending  = '0;
        w_slot_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_slot_off = AW'(i) - r_rptr;
            if ({1'b0, w_slot_off} < r_count) begin
                w_pending[r_mem_rd[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    // FIFO storage; contents are only meaningful inside the occupied window.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= bus.b_rd;
            r_mem_data[r_wptr] <= bus.b_data;
        end
    end

    // FIFO pointers, occupancy and head starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop || !w_head) begin
                r_starve <= '0;
            end else if (w_issue_a && (r_starve != SW'(STARVE_LIMIT))) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    // Registered write port; address/data hold when nothing is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_issue_a || w_pop;
            if (w_issue_a) begin
                r_rf_waddr <= bus.a_rd;
                r_rf_wdata <= bus.a_data;
            end else if (w_pop) begin
                r_rf_waddr <= r_mem_rd[r_rptr];
                r_rf_wdata <= r_mem_data[r_rptr];
            end
        end
    end

    assign bus.a_stall    = w_a_req && w_force;
    assign bus.b_ready    = w_b_ready;
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_waddr   = r_rf_waddr;
    assign bus.rf_wdata   = r_rf_wdata;
    assign bus.pending    = w_pending;
    assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized
// run against a queue-based reference model of the arbitration rules.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.rf_wdata); end
        checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h want 0", bus.pending); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got %b want 1", bus.b_ready); end
        checks++; if (bus.a_stall !== 1'b0) begin errors++; $display("FAIL reset_a_stall: got %b want 0", bus.a_stall); end
    endtask

    task automatic test_a_write();
        @(negedge clk);
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF;
        #1;
        checks++; if (bus.a_stall !== 1'b0) begin errors++; $display("FAIL a_stall: got %b want 0", bus.a_stall); end
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL a_we: got %b want 1", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL a_waddr: got %0d want 5", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL a_wdata: got %h want deadbeef", bus.rf_wdata); end
        @(negedge clk);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL a_we_idle: got %b want 0", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL a_waddr_hold: got %0d want 5", bus.rf_waddr); end
    endtask

    task automatic test_b_single();
        @(negedge clk);
        bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h11;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL b1_ready: got %b want 1", bus.b_ready); end
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.fifo_count !== 2'd1) begin errors++; $display("FAIL b1_count: got %0d want 1", bus.fifo_count); end
        checks++; if (bus.pending[7] !== 1'b1) begin errors++; $display("FAIL b1_pending_set: got %b want 1", bus.pending[7]); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL b1_we_early: got %b want 0", bus.rf_we); end
        @(negedge clk);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h11) begin
            errors++; $display("FAIL b1_write: got we=%b addr=%0d data=%h want we=1 addr=7 data=11", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        checks++; if (bus.pending[7] !== 1'b0) begin errors++; $display("FAIL b1_pending_clr: got %b want 0", bus.pending[7]); end
        checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("FAIL b1_count_drain: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_starve();
        logic [4:0]  exp_addr [7];
        logic [31:0] exp_data [7];
        logic [4:0]  ard;
        exp_addr = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd3, 5'd14, 5'd4};
        exp_data = '{32'h10A, 32'h10B, 32'h10C, 32'h10D, 32'h33, 32'h10E, 32'h44};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== exp_addr[c-1] || bus.rf_wdata !== exp_data[c-1]) begin
                    errors++; $display("FAIL starve_write[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                                       c-1, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_addr[c-1], exp_data[c-1]);
                end
            end
            ard = (c < 5) ? 5'(10 + c) : 5'd14;
            bus.a_valid = (c <= 5);
            bus.a_rd    = ard;
            bus.a_data  = 32'h100 + 32'(ard);
            bus.b_valid = (c < 2);
            bus.b_rd    = 5'(3 + c);
            bus.b_data  = (c == 0) ? 32'h33 : 32'h44;
            #1;
            if (c == 2) begin
                checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL starve_full_ready: got %b want 0", bus.b_ready); end
                checks++; if (bus.fifo_count !== 2'd2) begin errors++; $display("FAIL starve_full_count: got %0d want 2", bus.fifo_count); end
            end
            if (c <= 5) begin
                checks++; if (bus.a_stall !== (c == 4)) begin
                    errors++; $display("FAIL starve_a_stall[%0d]: got %b want %b", c, bus.a_stall, (c == 4));
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== exp_addr[6] || bus.rf_wdata !== exp_data[6]) begin
            errors++; $display("FAIL starve_write[6]: got we=%b addr=%0d data=%h want we=1 addr=4 data=44", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("FAIL starve_drain: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_zero_rd();
        @(negedge clk);
        bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'h5555;
        bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h6666;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL zero_b_ready: got %b want 1", bus.b_ready); end
        checks++; if (bus.a_stall !== 1'b0) begin errors++; $display("FAIL zero_a_stall: got %b want 0", bus.a_stall); end
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("FAIL zero_count: got %0d want 0", bus.fifo_count); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL zero_we: got %b want 0", bus.rf_we); end
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL zero_pending: got %h want 0", bus.pending); end
    endtask

    task automatic test_stream();
        logic [36:0] expq [$];
        logic [36:0] e;
        int sent = 0;
        int done = 0;
        for (int cyc = 0; cyc < 40 && done < 10; cyc++) begin
            @(negedge clk);
            if (bus.rf_we === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL stream_extra_write: got addr=%0d with nothing outstanding", bus.rf_waddr);
                end else begin
                    e = expq.pop_front();
                    if (bus.rf_waddr !== e[36:32] || bus.rf_wdata !== e[31:0]) begin
                        errors++; $display("FAIL stream_order: got addr=%0d data=%h want addr=%0d data=%h", bus.rf_waddr, bus.rf_wdata, e[36:32], e[31:0]);
                    end
                end
                done++;
            end
            checks++; if (bus.fifo_count > 2'd2) begin errors++; $display("FAIL stream_count: got %0d want <=2", bus.fifo_count); end
            bus.b_valid = (sent < 10);
            bus.b_rd    = 5'(sent + 1);
            bus.b_data  = $urandom;
            #1;
            if (bus.b_valid && bus.b_ready) begin
                expq.push_back({bus.b_rd, bus.b_data});
                sent++;
            end
        end
        idle_inputs();
        checks++; if (done != 10) begin errors++; $display("FAIL stream_timeout: got %0d writes want 10", done); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.a_valid = 1'b1; bus.a_rd = 5'd9; bus.a_data = 32'h99;
        bus.b_valid = 1'b1; bus.b_rd = 5'd20; bus.b_data = 32'h20;
        @(negedge clk);
        bus.b_rd = 5'd21; bus.b_data = 32'h21;
        @(negedge clk);
        bus.b_valid = 1'b0;
        #1;
        checks++; if (bus.fifo_count !== 2'd2 || bus.pending[20] !== 1'b1 || bus.pending[21] !== 1'b1) begin
            errors++; $display("FAIL rstmid_fill: got count=%0d pending=%h want count=2 bits 20,21", bus.fifo_count, bus.pending);
        end
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL rstmid_pending: got %h want 0", bus.pending); end
        checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.fifo_count); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b want 0", bus.rf_we); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.rf_we !== 1'b0 || bus.fifo_count !== 2'd0) begin
                errors++; $display("FAIL rstmid_stale[%0d]: got we=%b count=%0d want we=0 count=0", c, bus.rf_we, bus.fifo_count);
            end
        end
    endtask

    task automatic test_random();
        logic [36:0] q [$];
        logic [36:0] h;
        int          starve = 0;
        logic        exp_we = 1'b0;
        logic [4:0]  exp_addr = '0;
        logic [31:0] exp_data = '0;
        logic        stalled = 1'b0;
        logic [31:0] exp_pend;
        logic        a_req, head, forced, b_rdy;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            checks++; if (bus.rf_we !== exp_we || (exp_we && (bus.rf_waddr !== exp_addr || bus.rf_wdata !== exp_data))) begin
                errors++; $display("FAIL rand_write[%0d]: got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                                   cyc, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_we, exp_addr, exp_data);
            end
            if (!stalled) begin
                bus.a_valid = ($urandom_range(0, 99) < 55);
                bus.a_rd    = 5'($urandom_range(0, 7));
                bus.a_data  = $urandom;
            end
            bus.b_valid = ($urandom_range(0, 99) < 50);
            bus.b_rd    = 5'($urandom_range(0, 7));
            bus.b_data  = $urandom;
            #1;
            a_req  = bus.a_valid && bus.a_rd != 0;
            head   = q.size() > 0;
            forced = head && starve == LIMIT;
            b_rdy  = q.size() != DEPTH;
            exp_pend = '0;
            foreach (q[i]) exp_pend[q[i][36:32]] = 1'b1;
            checks++; if (bus.a_stall !== (a_req && forced) || bus.b_ready !== b_rdy) begin
                errors++; $display("FAIL rand_hs[%0d]: got stall=%b ready=%b want stall=%b ready=%b", cyc, bus.a_stall, bus.b_ready, a_req && forced, b_rdy);
            end
            checks++; if (bus.pending !== exp_pend || bus.fifo_count !== 2'(q.size())) begin
                errors++; $display("FAIL rand_state[%0d]: got pending=%h count=%0d want pending=%h count=%0d", cyc, bus.pending, bus.fifo_count, exp_pend, q.size());
            end
            stalled = a_req && forced;
            exp_we  = 1'b0;
            if (a_req && !forced) begin
                exp_we = 1'b1; exp_addr = bus.a_rd; exp_data = bus.a_data;
                starve = head ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
            end else if (head) begin
                h = q.pop_front();
                exp_we = 1'b1; exp_addr = h[36:32]; exp_data = h[31:0];
                starve = 0;
            end else begin
                starve = 0;
            end
            if (bus.b_valid && b_rdy && bus.b_rd != 0) q.push_back({bus.b_rd, bus.b_data});
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_a_write();
        test_b_single();
        test_starve();
        test_zero_rd();
        test_stream();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
